// File: rtl/count_arbiter.sv
// Round-robin arbiter that grants one requester at a time the shared counter datapath.
// Define COUNT_ARB_QUANTUM_EN to limit each grant to QUANTUM OWN cycles, with a preempt pulse.
module count_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int QUANTUM = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       cnt_clr,
    output logic                       cnt_en,
    output logic                       preempt
);
    localparam int IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || QUANTUM < 1 || QUANTUM > 255) begin : g_bad_param
        $error("count_arbiter: NUM_REQ must be 2..8 and QUANTUM 1..255");
    end

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_OWN} state_t;

    state_t             r_state, w_state;
    logic [NUM_REQ-1:0] r_gnt, w_gnt;
    logic [IDW-1:0]     r_gnt_id, w_gnt_id;
    logic [IDW-1:0]     r_ptr, w_ptr;
    logic               r_clr, w_clr;
    logic               r_en, w_en;
    logic               w_found;
    logic [IDW-1:0]     w_pick;
    logic               w_own_req;

`ifdef COUNT_ARB_QUANTUM_EN
    localparam int QW = $clog2(QUANTUM + 1);
    logic [QW-1:0] r_qcnt, w_qcnt;
    logic          r_preempt, w_preempt;
`endif

    // First set request at or after the pointer, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_pick  = IDW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_own_req = req[r_gnt_id];

    always_comb begin
        w_state  = r_state;
        w_gnt    = r_gnt;
        w_gnt_id = r_gnt_id;
        w_ptr    = r_ptr;
        w_clr    = 1'b0;
        w_en     = 1'b0;
`ifdef COUNT_ARB_QUANTUM_EN
        w_qcnt    = r_qcnt;
        w_preempt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state  = S_SETUP;
                    w_gnt    = NUM_REQ'(1) << w_pick;
                    w_gnt_id = w_pick;
                    w_clr    = 1'b1;
                    w_ptr    = (w_pick == IDW'(NUM_REQ - 1)) ? '0 : w_pick + IDW'(1);
                end
            end
            S_SETUP: begin
                if (w_own_req) begin
                    w_state = S_OWN;
                    w_en    = 1'b1;
`ifdef COUNT_ARB_QUANTUM_EN
                    w_qcnt  = '0;
`endif
                end else begin
                    w_state  = S_IDLE;
                    w_gnt    = '0;
                    w_gnt_id = '0;
                end
            end
            S_OWN: begin
                if (!w_own_req) begin
                    w_state  = S_IDLE;
                    w_gnt    = '0;
                    w_gnt_id = '0;
                end
`ifdef COUNT_ARB_QUANTUM_EN
                else if (r_qcnt == QW'(QUANTUM - 1)) begin
                    w_state   = S_IDLE;
                    w_gnt     = '0;
                    w_gnt_id  = '0;
                    w_preempt = 1'b1;
                end
`endif
                else begin
                    w_en = 1'b1;
`ifdef COUNT_ARB_QUANTUM_EN
                    if (r_qcnt != {QW{1'b1}}) w_qcnt = r_qcnt + QW'(1);
`endif
                end
            end
            default: begin
                w_state  = S_IDLE;
                w_gnt    = '0;
                w_gnt_id = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
            r_clr    <= 1'b0;
            r_en     <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_gnt    <= w_gnt;
            r_gnt_id <= w_gnt_id;
            r_ptr    <= w_ptr;
            r_clr    <= w_clr;
            r_en     <= w_en;
        end
    end

`ifdef COUNT_ARB_QUANTUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_qcnt    <= '0;
            r_preempt <= 1'b0;
        end else begin
            r_qcnt    <= w_qcnt;
            r_preempt <= w_preempt;
        end
    end
    assign preempt = r_preempt;
`else
    assign preempt = 1'b0;
`endif

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = |r_gnt;
    assign cnt_clr = r_clr;
    assign cnt_en  = r_en;
endmodule

// File: doc/count_arbiter.md
# count_arbiter

Round-robin arbiter that shares the single on-chip counter datapath between `NUM_REQ` requesters under `fpga_top`. It grants one requester at a time, clears the shared counter at the start of each grant, and gates the counter enable with the owner's request. With preemption compiled in, it also limits each grant to a fixed quantum.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `QUANTUM`, 8: maximum OWN cycles per grant, 1..255; used only with `COUNT_ARB_QUANTUM_EN`
- `clk` in 1: system clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `req` in `NUM_REQ`: per-requester request, level; bit i high means requester i wants the counter
- `gnt` out `NUM_REQ`: one-hot grant, or all zero
- `gnt_id` out `$clog2(NUM_REQ)`: index of the current owner; 0 when `gnt` is all zero
- `busy` out 1: high while any grant is active (`|gnt`)
- `cnt_clr` out 1: one-cycle synchronous clear strobe to the counter datapath
- `cnt_en` out 1: count enable to the counter datapath
- `preempt` out 1: one-cycle pulse when a grant ends by quantum expiry; always 0 without the macro

## Operation
- States: IDLE, SETUP, OWN. All outputs are registered.
- Reset (async, immediate):
  - state IDLE; `gnt`=0, `gnt_id`=0, `busy`=0, `cnt_clr`=0, `cnt_en`=0, `preempt`=0
  - round-robin pointer `ptr`=0; quantum counter `qcnt`=0
- IDLE:
  - Each cycle, search `req` starting at index `ptr`, wrapping modulo `NUM_REQ`.
  - First set bit i: next state SETUP, `gnt`=1<<i, `gnt_id`=i, `cnt_clr`=1, `ptr`=(i+1) mod `NUM_REQ`.
  - No bits set: stay in IDLE.
- SETUP (exactly 1 cycle):
  - `gnt` held, `cnt_clr`=1, `cnt_en`=0.
  - `req[gnt_id]`=1: next state OWN, `qcnt`=0.
  - `req[gnt_id]`=0: next state IDLE, grant dropped.
- OWN:
  - `cnt_en`=`req[gnt_id]` registered, so it is 1 on every OWN cycle that stays in OWN.
  - Owner deasserts `req[gnt_id]`: next state IDLE, `gnt`=0, `cnt_en`=0.
  - `qcnt` increments each OWN cycle (quantum rule under Configuration).
- Between two grants there is always at least one IDLE cycle with `gnt`=0. This holds even for back-to-back requests and a single persistent requester.
- Requests from non-owners during SETUP/OWN are ignored until IDLE. No requester is starved: after a grant to i, i has lowest priority.
- A `req` bit dropped while IDLE before being granted is simply not seen. No request latching.
- `gnt` is never multi-hot. `cnt_clr` and `cnt_en` are never high in the same cycle.

## Timing
- Arbitration latency: `req` high at edge k in IDLE gives `gnt`/`cnt_clr` high after edge k. Minimum request-to-grant is 1 cycle.
- Grant lifetime: SETUP is 1 cycle, then OWN for N cycles, then `gnt` low after the edge where the release condition is sampled.
- Release latency: owner `req` low sampled at edge m gives `gnt`=0 and `cnt_en`=0 after edge m. The counter sees no enable from edge m onward.
- `qcnt` is `$clog2(QUANTUM+1)` bits wide, saturating; no wrap.
- Reset mid-grant: `gnt`, `cnt_en` and `cnt_clr` drop asynchronously. `ptr` returns to 0, so the lowest set `req` wins first after release.

## Configuration
- `COUNT_ARB_QUANTUM_EN` defined:
  - In OWN, when `qcnt`=`QUANTUM`-1 and the owner still requests, next state is IDLE with `gnt`=0, `cnt_en`=0 and `preempt`=1 for that one cycle.
  - The owner therefore gets at most `QUANTUM` OWN cycles per grant. It may be re-granted later by normal round-robin.
- Undefined:
  - No preemption; a grant lasts until the owner releases.
  - `preempt` is tied 0 and `qcnt` is not implemented.

## Test plan
- Reset: assert `rst` mid-OWN with `req`=4'b0010 → `gnt`=0, `cnt_en`=0, `busy`=0 immediately; after release the first grant goes to requester 1 with `ptr`=0.
- Single request: `req`=4'b0100 at edge k → `gnt`=4'b0100, `gnt_id`=2, `cnt_clr`=1 after k; `cnt_en`=1 from k+1; drop `req` at edge k+6 → `gnt`=0 after k+6, exactly 5 `cnt_en` cycles.
- Round-robin: hold `req`=4'b1111, with each owner releasing after 2 OWN cycles → grant order 0,1,2,3,0 with one IDLE cycle between grants.
- Abort in SETUP: `req`=4'b0001 for exactly one cycle → one SETUP cycle with `cnt_clr`=1, then IDLE; `cnt_en` never asserts.
- Preemption (macro defined, `QUANTUM`=8): `req`=4'b0011 held → requester 0 gets 8 `cnt_en` cycles and `preempt` pulses once; then requester 1 is granted after one IDLE cycle.
- No preemption (macro undefined): same stimulus → requester 0 keeps `gnt` for 100+ cycles; `preempt` stays 0.
